// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - fetch-side bundle: instruction memory port, decode-side head port, redirect
interface ifu_prefetch_if #(
    parameter int ADDR_W = 14
);
    // instruction memory port
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    // head of the prefetch queue
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;
    logic              if_ready;
    // branch/jump restart
    logic              redirect;
    logic [31:0]       redirect_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetcher with one outstanding fetch; optional IFU_PERF_EN counters
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    ifu_prefetch_if.master       bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q;
    logic [31:0]     fetch_pc_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [63:0]     mem_q [DEPTH];

    logic            pop;
    logic            rsp;
    logic            push;
    logic [CW-1:0]   occ_post;
    logic            issue_idle;
    logic            issue_wait;
    logic [31:0]     req_pc;
    logic            unused_bits;

    // Handshake decode; a redirect always wins over pushes and new requests
    always_comb begin
        pop        = (count_q != '0) && bus.if_ready;
        rsp        = (state_q == WAIT) && bus.imem_rvalid;
        push       = rsp && !bus.redirect;
        occ_post   = count_q + CW'(push) - CW'(pop);
        issue_idle = (state_q == IDLE) && !bus.redirect && (count_q < CW'(DEPTH));
        // Back-to-back issue only when the response of the next request has a slot
        issue_wait = push && (occ_post < CW'(DEPTH));
        // A request issued alongside a push fetches the word after the one being pushed
        req_pc     = issue_wait ? (fetch_pc_q + 32'd4) : fetch_pc_q;
    end

    assign bus.imem_req  = cpu_rst && (issue_idle || issue_wait);
    assign bus.imem_addr = req_pc[ADDR_W+1:2];
    assign bus.if_valid  = (count_q != '0);
    assign bus.if_pc     = mem_q[rd_ptr_q][63:32];
    assign bus.if_inst   = mem_q[rd_ptr_q][31:0];
    assign unused_bits   = ^{req_pc, bus.redirect_pc[1:0]};

    // Fetch FSM: tracks whether the single outstanding request is live or stale
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_idle) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state_q <= issue_wait ? WAIT : IDLE;
                    end else if (bus.redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Fetch PC: restart on redirect, advance on every accepted response
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            fetch_pc_q <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst || bus.redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= occ_post;
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count
    always_ff @(posedge cpu_clk) begin
        if (push) mem_q[wr_ptr_q] <= {fetch_pc_q, bus.imem_rdata};
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    // Saturating event counters for accepted fetches and redirects
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push && (perf_fetch_q != 32'hFFFF_FFFF))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (bus.redirect && (perf_flush_q != 32'hFFFF_FFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed and random checks of ifu_prefetch against a queue-based model
module tb_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic cpu_rst = 1'b0;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ifu_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .cpu_clk        (clk),
        .cpu_rst        (cpu_rst),
        .bus            (bus)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // stimulus controls
    logic        rst_v = 1'b0;
    logic        ready_v = 1'b0;
    logic        redir_v = 1'b0;
    logic [31:0] rpc_v = '0;
    logic        stray_v = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;

    // memory model
    logic              mem_pend = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    int                mem_cnt = 0;

    // reference model
    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    logic        m_out = 1'b0;
    logic        m_stale = 1'b0;
    int          m_fetch = 0;
    int          m_flush = 0;

    logic        s_valid;
    logic [31:0] s_pc;

    function automatic logic [31:0] inst_of(input logic [ADDR_W-1:0] w);
        return ({18'b0, w} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        logic        rv;
        logic [31:0] rd;
        logic        pop, comp, push, e_req;
        logic [31:0] e_pc;
        ent_t        e;
        @(negedge clk);
        rv = 1'b0;
        rd = '0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                rv = 1'b1;
                rd = inst_of(mem_addr);
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (stray_v && !rv) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        cpu_rst         = rst_v;
        bus.if_ready    = ready_v;
        bus.redirect    = redir_v;
        bus.redirect_pc = rpc_v;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #1;
        s_valid = bus.if_valid;
        s_pc    = bus.if_pc;
        if (!rst_v) begin
            chk("req_in_reset", 32'(bus.imem_req), 32'd0);
            q.delete();
            m_pc = RESET_PC;
            m_out = 1'b0;
            m_stale = 1'b0;
            mem_pend = 1'b0;
            m_fetch = 0;
            m_flush = 0;
        end else begin
`ifdef IFU_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
            chk("perf_flush", perf_flush_cnt, 32'(m_flush));
`endif
            pop  = (q.size() > 0) && ready_v;
            comp = m_out && rv;
            push = comp && !m_stale && !redir_v;
            if (redir_v)      e_req = 1'b0;
            else if (!m_out)  e_req = (q.size() < DEPTH);
            else if (push)    e_req = ((q.size() + 1 - (pop ? 1 : 0)) < DEPTH);
            else              e_req = 1'b0;
            e_pc = push ? (m_pc + 32'd4) : m_pc;

            chk("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("if_pc", bus.if_pc, q[0].pc);
                chk("if_inst", bus.if_inst, q[0].inst);
            end
            chk("imem_req", 32'(bus.imem_req), 32'(e_req));
            if (e_req && bus.imem_req)
                chk("imem_addr", 32'(bus.imem_addr), 32'(e_pc[ADDR_W+1:2]));
            if (bus.imem_req) begin
                mem_pend = 1'b1;
                mem_addr = bus.imem_addr;
                mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            end

            if (redir_v) begin
                m_flush++;
                q.delete();
                m_pc = {rpc_v[31:2], 2'b00};
                if (m_out) begin
                    if (rv) m_out = 1'b0;
                    else    m_stale = 1'b1;
                end
            end else begin
                if (comp) m_out = 1'b0;
                if (push) begin
                    e.pc   = m_pc;
                    e.inst = inst_of(m_pc[ADDR_W+1:2]);
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                    m_fetch++;
                end
                if (pop) void'(q.pop_front());
                if (e_req) begin
                    m_out = 1'b1;
                    m_stale = 1'b0;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        bit found;
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // reset
        rst_v = 1'b0;
        cycle();
        cycle();
        rst_v = 1'b1;

        // streaming with 1-cycle memory and an always-ready consumer
        lat_min = 1; lat_max = 1; ready_v = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("seq_valid", 32'(s_valid), 32'd1);
            chk("seq_pc", s_pc, 32'(k * 4));
        end
        for (int k = 0; k < 6; k++) cycle();

        // stalled consumer fills the queue and stops fetching
        ready_v = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        ready_v = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        // redirect to 0x103 while waiting, stale response two cycles later
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_out && mem_pend && mem_cnt == 2) found = 1'b1;
            else cycle();
        end
        chk("reach_wait", 32'(found), 32'd1);
        redir_v = 1'b1; rpc_v = 32'h0000_0103;
        cycle();
        redir_v = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (q.size() > 0) found = 1'b1;
        end
        chk("redir_fill", 32'(found), 32'd1);
        #1;
        chk("redir_first_pc", bus.if_pc, 32'h0000_0100);

        // redirect coincident with a response and a pop
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_out && mem_pend && mem_cnt == 0 && q.size() > 0) found = 1'b1;
            else cycle();
        end
        chk("reach_stream", 32'(found), 32'd1);
        redir_v = 1'b1; rpc_v = 32'h0000_2468;
        cycle();
        #1;
        redir_v = 1'b0;
        bus.redirect = 1'b0;
        bus.imem_rvalid = 1'b0;
        #1;
        chk("coinc_empty", 32'(bus.if_valid), 32'd0);
        chk("coinc_req", 32'(bus.imem_req), 32'd1);
        chk("coinc_addr", 32'(bus.imem_addr), 32'(14'h091A));
        for (int k = 0; k < 6; k++) cycle();

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int k = 0; k < 400; k++) begin
            ready_v = ($urandom_range(3, 0) != 0);
            redir_v = ($urandom_range(15, 0) == 0);
            rpc_v   = $urandom;
            cycle();
        end
        redir_v = 1'b0;

        // reset while waiting, stray response right after release
        ready_v = 1'b1; lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_out && mem_pend && mem_cnt >= 1) found = 1'b1;
            else cycle();
        end
        chk("reach_wait2", 32'(found), 32'd1);
        rst_v = 1'b0;
        cycle();
        rst_v = 1'b1; stray_v = 1'b1;
        cycle();
        stray_v = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (q.size() > 0) found = 1'b1;
        end
        chk("rst_fill", 32'(found), 32'd1);
        #1;
        chk("rst_first_pc", bus.if_pc, RESET_PC);

        // ten fetches and two redirects after the reset
        lat_min = 1; lat_max = 1; ready_v = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_fetch >= 10) found = 1'b1;
            else cycle();
        end
        chk("perf_fill", 32'(found), 32'd1);
        redir_v = 1'b1; rpc_v = 32'h0000_0400;
        cycle();
        redir_v = 1'b0;
        cycle();
        redir_v = 1'b1; rpc_v = 32'h0000_0800;
        cycle();
        redir_v = 1'b0;
        ready_v = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, meaning: prefetch FIFO entries; a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 14, meaning: width of the word address sent to instruction memory.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-004 cpu_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 cpu_rst  in  1  reset, synchronous and active-low.
REQ-006 imem_req  out  1  one-cycle request pulse; accepted unconditionally by memory.
REQ-007 imem_addr  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
REQ-008 imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req.
REQ-009 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-010 if_valid  out  1  FIFO head holds a valid instruction.
REQ-011 if_pc  out  32  PC of the head entry.
REQ-012 if_inst  out  32  instruction of the head entry.
REQ-013 if_ready  in  1  consumer takes the head when if_valid is also high.
REQ-014 redirect  in  1  flush plus restart strobe from branch/jump resolution.
REQ-015 redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0.

Function
REQ-016 The FSM SHALL have three states: IDLE (nothing outstanding), WAIT (one request outstanding) and DROP (one stale request outstanding).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 IDLE: when occupancy < DEPTH and redirect is low, assert imem_req and go to WAIT.
REQ-019 WAIT, imem_rvalid high: push {fetch_pc, imem_rdata} and set fetch_pc to fetch_pc+4, wrapping modulo 2^32.
REQ-020 In the same cycle as REQ-019, if post-push occupancy (pops counted) < DEPTH, issue the next request and stay in WAIT; otherwise go to IDLE.
REQ-021 Sustained throughput SHALL be one instruction per cycle with single-cycle memory latency and an always-ready consumer.
REQ-022 A request SHALL be issued only if its response has a reserved FIFO slot, so a push never hits a full FIFO.
REQ-023 Pop occurs on if_valid and if_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 redirect SHALL in the same edge empty the FIFO and load fetch_pc with {redirect_pc[31:2], 2'b00}; if_valid is low the next cycle.
REQ-025 Redirect in WAIT without imem_rvalid goes to DROP; redirect in WAIT with imem_rvalid discards that response and goes to IDLE.
REQ-026 DROP: the next imem_rvalid SHALL be discarded, then go to IDLE; a redirect in DROP updates fetch_pc and stays in DROP.
REQ-027 A redirect coincident with a pop or push SHALL take priority; no entry survives.
REQ-028 imem_rvalid in IDLE SHALL be ignored.
REQ-029 if_pc and if_inst SHALL be held stable while if_valid is high and if_ready is low.

Reset
REQ-030 On cpu_rst low at a clock edge, the block SHALL set: FSM to IDLE, fetch_pc to RESET_PC, FIFO empty, imem_req 0, if_valid 0.
REQ-031 Reset during WAIT SHALL abandon the request; a late imem_rvalid afterwards falls under REQ-028.
REQ-032 The first request SHALL issue in the first cycle after cpu_rst returns high.

Configuration
REQ-033 Macro IFU_PERF_EN, when defined, adds outputs perf_fetch_cnt[31:0] (responses pushed) and perf_flush_cnt[31:0] (redirects).
REQ-034 Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-035 Without IFU_PERF_EN, these ports and counters SHALL be absent, with no other behavioural change.

Verification
REQ-036 RESET_PC=0, 1-cycle memory, if_ready=1: if_pc sequence 0,4,8,C on consecutive cycles after first fill.
REQ-037 if_ready=0, DEPTH=4: exactly 4 entries, PCs 0..C; then imem_req stays low; no overflow.
REQ-038 Redirect to 0x103 while WAIT, rvalid 2 cycles later: stale word dropped; next if_pc=0x100.
REQ-039 Redirect coincident with imem_rvalid and a pop: FIFO empty next cycle, new request at redirect target.
REQ-040 cpu_rst low mid-WAIT, stray imem_rvalid after release: ignored; first if_pc=RESET_PC.
REQ-041 IFU_PERF_EN: 10 fetches and 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2.
